// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready stage with a two-entry skid buffer, flush,
// NOP insertion on bubbles and a saturating stall counter.
//
// state   | meaning
// --------+--------------------------------------------
// S_EMPTY | nothing held, level 0
// S_FULL  | main entry valid, level 1
// S_SKID  | main and skid entries valid, level 2
module id_ex_pipe_reg #(
    parameter int                 OPC_W       = 8,
    parameter int                 MODE_W      = 2,
    parameter int                 DATA_W      = 16,
    parameter int                 REG_AW      = 4,
    parameter logic [OPC_W-1:0]   NOP_OPCODE  = 8'h00,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPC_W-1:0]       opcode_in,
    input  logic [MODE_W-1:0]      mode_in,
    input  logic [DATA_W-1:0]      op1_in,
    input  logic [DATA_W-1:0]      op2_in,
    input  logic [REG_AW-1:0]      wb_reg_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPC_W-1:0]       opcode_out,
    output logic [MODE_W-1:0]      mode_out,
    output logic [DATA_W-1:0]      op1_out,
    output logic [DATA_W-1:0]      op2_out,
    output logic [REG_AW-1:0]      wb_reg_out,
    output logic [1:0]             level,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [REG_AW-1:0] wb;
    } payload_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    payload_t               main_q, main_d;
    payload_t               skid_q, skid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    payload_t in_pl;
    logic     accept;
    logic     drain;
    logic     main_valid;

    assign in_pl      = '{opc: opcode_in, mode: mode_in, op1: op1_in, op2: op2_in, wb: wb_reg_in};
    assign main_valid = (state_q != S_EMPTY);
    assign accept     = in_valid & in_ready_q;
    assign drain      = main_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                    main_d  = in_pl;
                end
            end
            S_FULL: begin
                if (accept && drain) begin
                    main_d = in_pl;
                end else if (accept) begin
                    state_d = S_SKID;
                    skid_d  = in_pl;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_SKID: begin
                if (drain) begin
                    state_d = S_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush wins over any handshake; payload flops keep stale data, masked by valid.
        if (flush) begin
            state_d = S_EMPTY;
        end

        in_ready_d = (state_d != S_SKID);

        if (main_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid;
    assign opcode_out = main_valid ? main_q.opc : NOP_OPCODE;
    assign wb_reg_out = main_valid ? main_q.wb : '0;
    assign mode_out   = main_q.mode;
    assign op1_out    = main_q.op1;
    assign op2_out    = main_q.op2;
    assign level      = state_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a FIFO model of held instructions predicts
// handshake, occupancy, payload and stall count every cycle.
module tb_id_ex_pipe_reg;

    localparam int OPC_W  = 8;
    localparam int MODE_W = 2;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int SCW    = 3;
    localparam int SAT    = 7;
    localparam logic [7:0] NOP = 8'h00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  opcode_in;
    logic [MODE_W-1:0] mode_in;
    logic [DATA_W-1:0] op1_in;
    logic [DATA_W-1:0] op2_in;
    logic [REG_AW-1:0] wb_reg_in;
    logic              out_valid;
    logic              out_ready;
    logic [OPC_W-1:0]  opcode_out;
    logic [MODE_W-1:0] mode_out;
    logic [DATA_W-1:0] op1_out;
    logic [DATA_W-1:0] op2_out;
    logic [REG_AW-1:0] wb_reg_out;
    logic [1:0]        level;
    logic [SCW-1:0]    stall_cnt;

    id_ex_pipe_reg #(
        .OPC_W(OPC_W), .MODE_W(MODE_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
        .NOP_OPCODE(NOP), .STALL_CNT_W(SCW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .mode_in(mode_in), .op1_in(op1_in), .op2_in(op2_in),
        .wb_reg_in(wb_reg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_out(opcode_out), .mode_out(mode_out), .op1_out(op1_out), .op2_out(op2_out),
        .wb_reg_out(wb_reg_out), .level(level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPC_W-1:0]  opc;
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [REG_AW-1:0] wb;
    } entry_t;

    entry_t exp_q[$];
    int     exp_stall;
    int     n_checks;
    int     n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("level", 64'(level), 64'(exp_q.size()));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        if (exp_q.size() != 0) begin
            chk("opcode_out", 64'(opcode_out), 64'(exp_q[0].opc));
            chk("mode_out", 64'(mode_out), 64'(exp_q[0].mode));
            chk("op1_out", 64'(op1_out), 64'(exp_q[0].op1));
            chk("op2_out", 64'(op2_out), 64'(exp_q[0].op2));
            chk("wb_reg_out", 64'(wb_reg_out), 64'(exp_q[0].wb));
        end else begin
            chk("nop_opcode", 64'(opcode_out), 64'(NOP));
            chk("nop_wb_reg", 64'(wb_reg_out), 64'd0);
        end
    endtask

    // One clock cycle: check current outputs, drive inputs, advance the model on the edge.
    task automatic cycle(input logic iv, input logic [7:0] op, input logic [31:0] d1,
                         input logic [4:0] wb, input logic ordy, input logic fl);
        entry_t e;
        logic   acc;
        logic   drn;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        opcode_in = op;
        mode_in   = op[1:0];
        op1_in    = d1;
        op2_in    = ~d1;
        wb_reg_in = wb;
        out_ready = ordy;
        flush     = fl;
        e   = '{opc: op, mode: op[1:0], op1: d1, op2: ~d1, wb: wb};
        acc = iv && (exp_q.size() != 2);
        drn = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if ((exp_q.size() != 0) && !ordy && (exp_stall != SAT)) exp_stall++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_opcode"}, 64'(opcode_out), 64'(NOP));
        chk({tag, "_op1"}, 64'(op1_out), 64'd0);
        chk({tag, "_op2"}, 64'(op2_out), 64'd0);
        chk({tag, "_mode"}, 64'(mode_out), 64'd0);
        chk({tag, "_wb"}, 64'(wb_reg_out), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_pulse");
        exp_q.delete();
        exp_stall = 0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        opcode_in = '0;
        mode_in   = '0;
        op1_in    = '0;
        op2_in    = '0;
        wb_reg_in = '0;
        out_ready = 1'b0;
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Streaming at full throughput
        cycle(1, 8'h11, 32'h0000_1111, 5'd1, 1, 0);
        #1;
        chk("stream_first_opc", 64'(opcode_out), 64'h11);
        chk("stream_first_level", 64'(level), 64'd1);
        cycle(1, 8'h12, 32'h0000_2222, 5'd2, 1, 0);
        cycle(1, 8'h13, 32'h0000_3333, 5'd3, 1, 0);
        #1;
        chk("stream_last_opc", 64'(opcode_out), 64'h13);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        #1;
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure into the skid entry, offers while full must be refused
        cycle(1, 8'h21, 32'hA5A5_0021, 5'd4, 0, 0);
        cycle(1, 8'h22, 32'hA5A5_0022, 5'd5, 0, 0);
        #1;
        chk("skid_level", 64'(level), 64'd2);
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1, 8'h2F, 32'hFFFF_FFFF, 5'd31, 0, 0);
        #1;
        chk("skid_stall4", 64'(stall_cnt), 64'd4);
        chk("skid_head_opc", 64'(opcode_out), 64'h21);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        #1;
        chk("skid_drain1_opc", 64'(opcode_out), 64'h22);
        chk("skid_in_ready_back", 64'(in_ready), 64'd1);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);

        // Flush from SKID while 0x33 is offered, and from FULL while an accept happens
        cycle(1, 8'h31, 32'h0000_0031, 5'd6, 0, 0);
        cycle(1, 8'h32, 32'h0000_0032, 5'd7, 0, 0);
        cycle(1, 8'h33, 32'h0000_0033, 5'd8, 0, 1);
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_opcode", 64'(opcode_out), 64'(NOP));
        chk("flush_wb", 64'(wb_reg_out), 64'd0);
        chk("flush_level", 64'(level), 64'd0);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        cycle(1, 8'h35, 32'h0000_0035, 5'd9, 0, 0);
        cycle(1, 8'h36, 32'h0000_0036, 5'd10, 0, 1);
        #1;
        chk("flush_full_level", 64'(level), 64'd0);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);

        // Wide payload passes through unmodified
        cycle(1, 8'h5A, 32'hDEAD_BEEF, 5'd31, 0, 0);
        #1;
        chk("wide_op1", 64'(op1_out), 64'hDEAD_BEEF);
        chk("wide_op2", 64'(op2_out), 64'h2152_4110);
        chk("wide_wb", 64'(wb_reg_out), 64'd31);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);

        // Saturation of the 3-bit stall counter
        reset_pulse();
        cycle(1, 8'h61, 32'h0000_0061, 5'd11, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 8'h00, 32'h0, 5'd0, 0, 0);
        #1;
        chk("sat_stall", 64'(stall_cnt), 64'd7);
        cycle(0, 8'h00, 32'h0, 5'd0, 0, 0);
        #1;
        chk("sat_stall_hold", 64'(stall_cnt), 64'd7);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        #1;
        chk("sat_after_flushless_drain", 64'(stall_cnt), 64'd7);

        // Asynchronous reset while two entries are held
        cycle(1, 8'h71, 32'h0000_0071, 5'd12, 0, 0);
        cycle(1, 8'h72, 32'h0000_0072, 5'd13, 0, 0);
        #1;
        chk("pre_async_level", 64'(level), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        exp_q.delete();
        exp_stall = 0;
        #1;
        rst_n = 1'b1;
        cycle(1, 8'h44, 32'h0000_0044, 5'd14, 0, 0);
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_opc", 64'(opcode_out), 64'h44);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);
        cycle(0, 8'h00, 32'h0, 5'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register for the RISC-Net core. It replaces the fixed-width, always-advancing decode/execute latch with a valid/ready stage: a two-entry skid buffer with synchronous flush, NOP insertion on bubbles, and a saturating stall counter. It sits between the decode stage and the ALU/execute stage, so either side can stall without losing or duplicating an instruction.

## Interface
- OPC_W, 8: opcode width
- MODE_W, 2: addressing-mode width
- DATA_W, 16: operand width (op1, op2)
- REG_AW, 4: write-back register index width
- NOP_OPCODE, 8'h00: opcode presented when no valid instruction is held
- STALL_CNT_W, 16: stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discard all held and incoming instructions
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered, equals "skid entry empty"
- opcode_in, mode_in, op1_in, op2_in, wb_reg_in  in  OPC_W/MODE_W/DATA_W/DATA_W/REG_AW  decoded payload
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute consumes this cycle
- opcode_out, mode_out, op1_out, op2_out, wb_reg_out  out  same widths  payload of main entry
- level  out  2  occupancy: 0, 1 or 2
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Handshake terms: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY (level 0), FULL (main only, level 1), SKID (both, level 2).
- EMPTY: accept → FULL, main←input. No accept → stay.
- FULL, accept & drain → FULL, main←input.
- FULL, accept & !drain → SKID, skid←input.
- FULL, !accept & drain → EMPTY.
- FULL, neither → stay, main holds.
- SKID: in_ready=0, so no accept. Drain → FULL, main←skid. No drain → hold both.
- flush=1: next state EMPTY regardless of accept/drain. An input offered in the same cycle is dropped. in_ready is still driven normally that cycle.
- When out_valid=0, opcode_out=NOP_OPCODE and wb_reg_out=0. This is a combinational mux on the registered valid bit. mode_out, op1_out and op2_out are don't-care and are not checked.
- stall_cnt increments each cycle with out_valid & !out_ready and holds at all-ones. Flush does not clear it; only reset does.
- Ordering is strictly FIFO. The skid entry is always older than any later input.
- Payload is stored unmodified. No width conversion or sign extension.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, in_ready=1, out_valid=0, opcode_out=NOP_OPCODE, all other payload=0, level=0, stall_cnt=0.
- Reset release: the first active edge behaves as EMPTY.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N; one cycle.
- Throughput: one instruction per cycle when out_ready is held at 1.
- in_ready falls in the cycle after the stage enters SKID and rises in the cycle after the skid entry drains. It is never combinationally dependent on out_ready.
- Reset asserted mid-operation drops both entries immediately, without waiting for a clock edge.

## Test plan
- Streaming: out_ready=1, feed opcodes 0x11, 0x12, 0x13 on consecutive cycles → out_valid=1 with the same opcodes one cycle later each; level stays 1; stall_cnt=0.
- Backpressure and skid:
  - Feed 0x21, then 0x22, with out_ready=0 → level=2 and in_ready=0 after the second edge.
  - Hold out_ready=0 for 3 cycles → stall_cnt=4.
  - Release out_ready → outputs 0x21 then 0x22 in order, and in_ready returns to 1.
- Flush from SKID with in_valid=1 carrying 0x33 → next cycle out_valid=0, opcode_out=NOP_OPCODE, wb_reg_out=0, level=0, and 0x33 never appears.
- Wide parameters: DATA_W=32, REG_AW=5; op1_in=0xDEADBEEF, wb_reg_in=31 → identical values on the outputs.
- Saturation: STALL_CNT_W=3, hold the stall for 10 cycles → stall_cnt=7 and holds at 7.
- Asynchronous reset asserted mid-cycle while level=2 → outputs immediately take their reset values. After release, an accepted 0x44 appears after one edge.
